// File: rtl/music_pkg.sv
// Shared widths, player state encoding and the mid-octave half-period table
// for the buzzer note player.
package music_pkg;
    localparam int NOTE_BITS   = 3;
    localparam int OCT_BITS    = 2;
    localparam int LENGTH_BITS = 3;
    localparam int HP_BITS     = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } player_state_e;

    // Half-period in clk cycles at 100 MHz for the mid octave; 0 for rest.
    function automatic logic [HP_BITS-1:0] base_hp(input logic [NOTE_BITS-1:0] note);
        case (note)
            3'd1:    return 20'd191110;
            3'd2:    return 20'd170265;
            3'd3:    return 20'd151685;
            3'd4:    return 20'd143172;
            3'd5:    return 20'd127551;
            3'd6:    return 20'd113636;
            3'd7:    return 20'd101239;
            default: return '0;
        endcase
    endfunction
endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles the output every half_period cycles while
// enabled; output and counter are held at zero when disabled.
module tone_divider
    import music_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [HP_BITS-1:0] half_period,
    output logic               wave
);
    logic [HP_BITS-1:0] cnt_q, cnt_d;
    logic               wave_q, wave_d;

    always_comb begin
        cnt_d  = cnt_q + HP_BITS'(1);
        wave_d = wave_q;
        if (!enable) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (cnt_q == half_period - HP_BITS'(1)) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;
endmodule

// File: rtl/buzzer_note_player.sv
// Plays one {note, octave, length} request as a square wave followed by a
// silent gap. Define BUZZER_NOTE_PLAYER_ABORT_EN to add the abort input.
module buzzer_note_player
    import music_pkg::*;
#(
    parameter int TICK_CYCLES   = 100000,
    parameter int UNIT_TICKS    = 125,
    parameter int GAP_TICKS     = 20,
    parameter int SIM_DIV_SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef BUZZER_NOTE_PLAYER_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NOTE_BITS-1:0]   in_note,
    input  logic [OCT_BITS-1:0]    in_octave,
    input  logic [LENGTH_BITS-1:0] in_length,
    output logic                   buzzer,
    output logic                   busy,
    output logic                   done,
    output logic [NOTE_BITS-1:0]   cur_note,
    output logic [OCT_BITS-1:0]    cur_octave
);
    localparam int TK_MAX = (8 * UNIT_TICKS > GAP_TICKS) ? 8 * UNIT_TICKS : GAP_TICKS;
    localparam int TC_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int TK_W   = $clog2(TK_MAX + 1);
    localparam logic [TC_W-1:0] CYC_LAST = TC_W'(TICK_CYCLES - 1);
    localparam logic [TK_W-1:0] UNIT     = TK_W'(UNIT_TICKS);
    localparam logic [TK_W-1:0] GAP_LAST = TK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    player_state_e          state_q, state_d;
    logic [NOTE_BITS-1:0]   note_q, note_d;
    logic [OCT_BITS-1:0]    oct_q, oct_d;
    logic [LENGTH_BITS-1:0] len_q, len_d;
    logic [TC_W-1:0]        cyc_q, cyc_d;
    logic [TK_W-1:0]        tick_q, tick_d;
    logic                   done_q, done_d;

    logic                   abort_w;
    logic                   tick_wrap, play_end, gap_end, tone_en;
    logic [TK_W-1:0]        dur_last;
    logic [HP_BITS-1:0]     hp_base, hp_oct, hp;

`ifdef BUZZER_NOTE_PLAYER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign tick_wrap = (cyc_q == CYC_LAST);
    assign dur_last  = (TK_W'(len_q) + TK_W'(1)) * UNIT - TK_W'(1);
    assign play_end  = tick_wrap && (tick_q == dur_last);
    assign gap_end   = (GAP_TICKS == 0) || (tick_wrap && (tick_q == GAP_LAST));

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        oct_d   = oct_q;
        len_d   = len_q;
        cyc_d   = tick_wrap ? '0 : cyc_q + TC_W'(1);
        tick_d  = tick_wrap ? tick_q + TK_W'(1) : tick_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cyc_d  = '0;
                tick_d = '0;
                if (in_valid && !abort_w) begin
                    state_d = ST_PLAY;
                    note_d  = in_note;
                    // Octave 3 plays as high, so it is stored and shown as 2.
                    oct_d   = (in_octave == 2'd3) ? 2'd2 : in_octave;
                    len_d   = in_length;
                end
            end
            ST_PLAY: begin
                if (play_end) begin
                    state_d = ST_GAP;
                    tick_d  = '0;
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    note_d  = '0;
                    oct_d   = '0;
                    cyc_d   = '0;
                    tick_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_w && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            note_d  = '0;
            oct_d   = '0;
            cyc_d   = '0;
            tick_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            note_q  <= '0;
            oct_q   <= '0;
            len_q   <= '0;
            cyc_q   <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            len_q   <= len_d;
            cyc_q   <= cyc_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign hp_base = base_hp(note_q);
    assign hp_oct  = (oct_q == 2'd0) ? (hp_base << 1) :
                     (oct_q == 2'd1) ? hp_base : (hp_base >> 1);
    assign hp      = hp_oct >> SIM_DIV_SHIFT;

    // Enable only while staying in PLAY, so the edge leaving PLAY also
    // clears the wave and the acceptance edge leaves the counter at zero.
    assign tone_en = (state_q == ST_PLAY) && (state_d == ST_PLAY) && (note_q != '0);

    tone_divider u_tone (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (tone_en),
        .half_period (hp),
        .wave        (buzzer)
    );

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign cur_note   = note_q;
    assign cur_octave = oct_q;
endmodule

// File: tb/tb_buzzer_note_player.sv
// Self-checking bench for buzzer_note_player: table of toggle/done timings,
// randomized notes against a cycle-level waveform model, reset/abort cases.
module tb_buzzer_note_player;
    localparam int TC    = 100;
    localparam int UNIT  = 4;
    localparam int GAP   = 1;
    localparam int SHIFT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_note = '0;
    logic [1:0] in_octave = '0;
    logic [2:0] in_length = '0;
    logic       in_ready, buzzer, busy, done;
    logic [2:0] cur_note;
    logic [1:0] cur_octave;
`ifdef BUZZER_NOTE_PLAYER_ABORT_EN
    logic       abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    buzzer_note_player #(
        .TICK_CYCLES(TC), .UNIT_TICKS(UNIT), .GAP_TICKS(GAP), .SIM_DIV_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef BUZZER_NOTE_PLAYER_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_note(in_note),
        .in_octave(in_octave), .in_length(in_length), .buzzer(buzzer),
        .busy(busy), .done(done), .cur_note(cur_note), .cur_octave(cur_octave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference half-period: mid-octave table, doubled for low, halved for high.
    function automatic int model_hp(input int n, input int o);
        int b[8] = '{0, 191110, 170265, 151685, 143172, 127551, 113636, 101239};
        int h;
        h = (o == 0) ? b[n] * 2 : (o == 1) ? b[n] : b[n] / 2;
        return h >> SHIFT;
    endfunction

    // {buzzer, busy, done, in_ready, cur_note, cur_octave}
    function automatic logic [8:0] outs();
        return {buzzer, busy, done, in_ready, cur_note, cur_octave};
    endfunction

    task automatic accept(input int n, input int o, input int l, output bit ok);
        int w = 0;
        in_note = n[2:0]; in_octave = o[1:0]; in_length = l[2:0]; in_valid = 1'b1;
        while (!in_ready && w < 10000) begin @(posedge clk); #1; w++; end
        ok = in_ready;
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_note(input int n, input int o, input int l, input bit hold,
                            input int n2, input int o2, input int l2,
                            output int rise_t, output int fall_t, output int done_t);
        int hp, d, last, bad_t;
        bit ok;
        logic [8:0] e, a, bad_e, bad_a;
        logic [2:0] en;
        logic [1:0] eo;
        rise_t = -1; fall_t = -1; done_t = -1; bad_t = -1; bad_e = '0; bad_a = '0;
        accept(n, o, l, ok);
        if (!ok) return;
        if (hold) begin
            in_note = n2[2:0]; in_octave = o2[1:0]; in_length = l2[2:0];
        end else begin
            in_valid = 1'b0;
        end
        hp   = (n != 0) ? model_hp(n, o) : 1;
        d    = (l + 1) * UNIT * TC;
        last = d + GAP * TC;
        en   = n[2:0];
        eo   = (o == 3) ? 2'd2 : o[1:0];
        for (int t = 0; t <= last; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            e = {(n != 0 && t < d) ? 1'((t / hp) % 2) : 1'b0,
                 1'(t < last), 1'(t == last), 1'(t == last),
                 (t < last) ? en : 3'd0, (t < last) ? eo : 2'd0};
            a = outs();
            if (a !== e && bad_t < 0) begin bad_t = t; bad_e = e; bad_a = a; end
            if (buzzer && rise_t < 0) rise_t = t;
            if (!buzzer && rise_t >= 0 && fall_t < 0) fall_t = t;
            if (done && done_t < 0) done_t = t;
        end
        checks++;
        if (bad_t >= 0) begin
            errors++;
            $display("FAIL wave n=%0d o=%0d l=%0d t=%0d: got %b want %b", n, o, l, bad_t, bad_a, bad_e);
        end
    endtask

    typedef struct {
        int n; int o; int l;
        int rise; int fall; int dn;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int r, f, dn, n, o, l;
        bit ok, saw_done;

        vecs[0] = '{n:6, o:1, l:1, rise:110, fall:220, dn:900};
        vecs[1] = '{n:1, o:0, l:1, rise:373, fall:746, dn:900};
        vecs[2] = '{n:1, o:1, l:0, rise:186, fall:372, dn:500};
        vecs[3] = '{n:1, o:2, l:0, rise:93,  fall:186, dn:500};
        vecs[4] = '{n:1, o:3, l:0, rise:93,  fall:186, dn:500};
        vecs[5] = '{n:0, o:0, l:0, rise:-1,  fall:-1,  dn:500};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", int'(outs()), int'(9'b0_0_0_1_000_00));
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_note(vecs[i].n, vecs[i].o, vecs[i].l, 1'b0, 0, 0, 0, r, f, dn);
            chk($sformatf("rise[%0d]", i), r, vecs[i].rise);
            chk($sformatf("fall[%0d]", i), f, vecs[i].fall);
            chk($sformatf("done_t[%0d]", i), dn, vecs[i].dn);
        end

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(0, 7); o = $urandom_range(0, 3); l = $urandom_range(0, 3);
            run_note(n, o, l, 1'b0, 0, 0, 0, r, f, dn);
        end

        // Back-to-back: valid held; second request must land on the edge after done.
        run_note(2, 1, 0, 1'b1, 3, 2, 0, r, f, dn);
        run_note(3, 2, 0, 1'b0, 0, 0, 0, r, f, dn);
        chk("b2b_second_done", dn, 500);

        // Reset mid-PLAY at cycle 300; note 2 mid has HP 166 so buzzer is high then.
        accept(2, 1, 3, ok);
        in_valid = 1'b0;
        repeat (299) begin @(posedge clk); #1; end
        chk("pre_reset_buzzer", int'(buzzer), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_outs", int'(outs()), int'(9'b0_0_0_1_000_00));
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (1200) begin @(posedge clk); #1; if (done || busy) saw_done = 1'b1; end
        chk("post_reset_quiet", int'(saw_done), 0);

`ifdef BUZZER_NOTE_PLAYER_ABORT_EN
        accept(2, 1, 3, ok);
        in_valid = 1'b0;
        repeat (199) begin @(posedge clk); #1; end
        chk("pre_abort_busy", int'(busy), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("post_abort_outs", int'(outs()), int'(9'b0_0_0_1_000_00));
        saw_done = 1'b0;
        repeat (1200) begin @(posedge clk); #1; if (done || busy) saw_done = 1'b1; end
        chk("post_abort_quiet", int'(saw_done), 0);
        // Abort in IDLE wins over a simultaneous request.
        abort = 1'b1; in_valid = 1'b1; in_note = 3'd4; in_octave = 2'd1; in_length = 3'd0;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("idle_abort_outs", int'(outs()), int'(9'b0_0_0_1_000_00));
        @(posedge clk); #1;
        chk("idle_abort_no_accept", int'(busy), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/buzzer_note_player.md
Name: buzzer_note_player

Overview:
- Downstream consumer of the key/translation controller.
- Accepts one {note, octave, length} request at a time over a valid/ready handshake.
- Drives the buzzer with a square wave of the note's pitch for the length's duration, then holds a short silent articulation gap before accepting the next note.
- Exposes the currently sounding note and octave for the 7-segment display stage.

Parameters:
- TICK_CYCLES, 100000: clk cycles per duration tick (1 ms at 100 MHz).
- UNIT_TICKS, 125: ticks per length unit.
- GAP_TICKS, 20: ticks of silence after each note.
- SIM_DIV_SHIFT, 0: right-shift applied to every half-period value; nonzero only in simulation.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_note  in  3  0 = rest, 1..7 = do..si.
- in_octave  in  2  0 = low, 1 = mid, 2 = high; 3 is treated as high.
- in_length  in  3  duration = (in_length+1)*UNIT_TICKS ticks.
- buzzer  out  1  square-wave output.
- busy  out  1  high in PLAY or GAP.
- done  out  1  one-cycle pulse when a note's gap completes.
- cur_note  out  3  note being played; 0 when idle.
- cur_octave  out  2  octave being played; 0 when idle.

Behaviour:
- Reset: rst_n low at a clk edge puts the block in IDLE and clears every counter. Output values after that edge: buzzer=0, busy=0, done=0, cur_note=0, cur_octave=0, in_ready=1. Applies equally mid-PLAY or mid-GAP.
- States: IDLE, PLAY, GAP.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge N: latch note/octave/length, clear the tick and tone counters, go to PLAY.
  - busy=1 and cur_note/cur_octave valid from edge N.
- PLAY:
  - in_ready=0; in_valid is ignored.
  - Half-period HP = base_hp[note] (mid octave, 20-bit): C 191110, D 170265, E 151685, F 143172, G 127551, A 113636, B 101239.
  - Octave adjustment: low = HP<<1, high = HP>>1. Then apply >>SIM_DIV_SHIFT.
  - Tone counter counts 0..HP-1; buzzer toggles when it wraps. First toggle occurs HP cycles after acceptance; buzzer starts at 0.
  - note=0 (rest): buzzer held 0 for the full duration.
  - Tick counter counts 0..TICK_CYCLES-1; each wrap is one tick.
  - After (in_length+1)*UNIT_TICKS ticks: buzzer forced to 0, tone counter cleared, go to GAP.
- GAP:
  - buzzer=0.
  - After GAP_TICKS ticks: one-cycle done pulse, go to IDLE.
  - busy=0, cur_note=0 and cur_octave=0 from that same edge.
  - in_ready returns to 1 in the cycle done is high. Earliest next acceptance is at the edge ending that cycle.
- GAP_TICKS=0: GAP lasts exactly one cycle, which carries the done pulse.
- Arithmetic:
  - Duration product is at most 8*UNIT_TICKS; tick count width is clog2(8*UNIT_TICKS+1).
  - Counters saturate nowhere; compares are exact-equality.

Optional Feature:
- Macro: BUZZER_NOTE_PLAYER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high at an edge while in PLAY or GAP: go to IDLE. buzzer=0, busy=0, cur_note=0, cur_octave=0 from that edge. No done pulse.
  - abort in IDLE has no effect. abort takes priority over an acceptance in the same cycle; in_ready stays 1.
- Undefined: the port is absent and a note always plays to completion.

Decomposition:
- Package music_pkg:
  - NOTE_BITS=3, OCT_BITS=2, LENGTH_BITS=3.
  - The base_hp half-period table as a constant function of note.
  - The player state encoding.
- One sub-module tone_divider:
  - Inputs: enable, 20-bit half-period.
  - Output: square wave.
  - Output and counter cleared when enable is low.

Test Plan (TICK_CYCLES=100, UNIT_TICKS=4, GAP_TICKS=1, SIM_DIV_SHIFT=10 unless stated):
- Mid A: note=6, octave=1, length=1 -> HP=110. buzzer toggles every 110 cycles for 800 cycles. Then 100 cycles low, then one done pulse; in_ready=1 in that same cycle.
- Octaves: note=1 low/mid/high -> toggle spacing 373/186/93 cycles; octave=3 gives the same spacing as high.
- Rest: note=0, length=0 -> buzzer stays 0 for 400 cycles, busy=1, done after 500 cycles.
- Back-to-back: in_valid held high with two requests -> second accepted exactly at the edge ending the done cycle, in_ready low throughout PLAY and GAP.
- Reset mid-PLAY: rst_n low for 1 cycle at cycle 300 -> next edge buzzer=0, busy=0, in_ready=1, no done pulse.
- ABORT_EN build: abort pulsed at cycle 200 of a note -> IDLE next edge, no done pulse; abort in IDLE leaves all outputs unchanged.
